// File: rtl/fifo_rd_stream.sv
// Show-ahead FIFO read-side consumer: pops into a 2-entry skid
// buffer and re-presents words as a registered valid/ready stream.
module fifo_rd_stream #(
  parameter int WIDTH   = 10,
  parameter int LAST_EN = 1,
  parameter int CNTW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  input  logic             fifo_err,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CNTW-1:0]  beat_cnt,
  output logic [CNTW-1:0]  pkt_cnt,
  output logic             in_pkt,
  output logic             idle,
  output logic             err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             take;
  logic             pop;

  // Pop depends only on registered occupancy, never on m_ready.
  assign pop      = rst_n & ~fifo_empty & (state_q != FULL);
  assign fifo_ren = pop;

  assign m_valid = (state_q != EMPTY);
  assign m_data  = main_q;
  assign take    = m_valid & m_ready;
  assign m_last  = (LAST_EN != 0) ? main_q[WIDTH-1] : 1'b1;
  assign idle    = (state_q == EMPTY) & ~in_pkt;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (pop) begin
          state_d = ONE;
          main_d  = fifo_rdata;
        end
      end
      ONE: begin
        if (pop && take) begin
          main_d = fifo_rdata;
        end else if (pop) begin
          state_d = FULL;
          skid_d  = fifo_rdata;
        end else if (take) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      pkt_cnt  <= '0;
      in_pkt   <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (take) begin
        beat_cnt <= beat_cnt + 1'b1;
        in_pkt   <= ~m_last;
      end
      if (take && m_last) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end
      if (fifo_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule
